// File: rtl/mpmc11_req_sched_if.sv
// Channel-FIFO and controller-core side signals of the mpmc11 read request scheduler.
// master: the scheduler; slave: the FIFO bank and controller core it connects to.
interface mpmc11_req_sched_if #(
    parameter int NCH = 8,
    parameter int EW  = 32
);
    localparam int CW = $clog2(NCH);

    typedef logic [EW-1:0] mpmc11_fifoe_t;

    logic [NCH-1:0]                fifo_empty;
    logic [NCH-1:0]                fifo_rst_busy;
    mpmc11_fifoe_t [NCH-1:0]       fifo_dout;
    logic [NCH-1:0]                fifo_rd;
    mpmc11_fifoe_t                 req;
    logic [CW-1:0]                 req_ch;
    logic                          req_valid;
    logic                          req_ready;
    logic                          rty;
    logic                          drop;
    logic                          busy;

    modport master (
        input  fifo_empty, fifo_rst_busy, fifo_dout, req_ready, rty,
        output fifo_rd, req, req_ch, req_valid, drop, busy
    );

    modport slave (
        output fifo_empty, fifo_rst_busy, fifo_dout, req_ready, rty,
        input  fifo_rd, req, req_ch, req_valid, drop, busy
    );
endinterface

// File: rtl/mpmc11_req_sched.sv
// Round-robin read request scheduler: pops one FWFT channel FIFO at a time and holds the
// request for the core until consumed. Optional retry limit: define MPMC11_SCHED_RTYLIM_EN.
//
// state | meaning
// IDLE  | nothing eligible, waiting for a channel
// GRANT | pop the round-robin winner and register its head entry
// HOLD  | request presented (req_valid=1) until the core consumes or retries it
// RWAIT | back-off after a retry; request held, req_valid=0
module mpmc11_req_sched #(
    parameter int NCH     = 8,
    parameter int RTY_DLY = 3,
    parameter int RTY_MAX = 15,
    parameter int EW      = 32
) (
    input  logic               rd_clk,
    input  logic               rst,
    mpmc11_req_sched_if.master bus
);
    localparam int CW = $clog2(NCH);

`ifdef MPMC11_SCHED_RTYLIM_EN
    localparam bit RTYLIM_EN = 1'b1;
`else
    localparam bit RTYLIM_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, GRANT, HOLD, RWAIT} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  rr_ptr;
    logic [3:0]     rty_cnt;
    logic [3:0]     dly_cnt;
    logic [EW-1:0]  req_q;
    logic [CW-1:0]  req_ch_q;
    logic           drop_q, drop_nxt;
    logic           retry;
    logic           rty_over;

    logic [NCH-1:0] elig;
    logic           any_elig;
    logic [CW-1:0]  pick, pick_hi, pick_lo;
    logic           found_hi;
    logic [NCH-1:0] rd_vec;

    assign elig     = ~bus.fifo_empty & ~bus.fifo_rst_busy;
    assign any_elig = |elig;

    // Winner is the lowest eligible channel above rr_ptr, else wrap to the lowest eligible.
    always_comb begin
        pick_hi  = '0;
        pick_lo  = '0;
        found_hi = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (elig[i]) begin
                pick_lo = CW'(i);
                if (CW'(i) > rr_ptr) begin
                    pick_hi  = CW'(i);
                    found_hi = 1'b1;
                end
            end
        end
        pick = found_hi ? pick_hi : pick_lo;
    end

    always_comb begin
        rd_vec = '0;
        if (state == GRANT && any_elig && !rst)
            rd_vec[pick] = 1'b1;
    end

    assign rty_over = RTYLIM_EN && (int'(rty_cnt) + 1 > RTY_MAX);

    always_comb begin
        state_nxt = state;
        drop_nxt  = 1'b0;
        retry     = 1'b0;
        case (state)
            IDLE:  if (any_elig) state_nxt = GRANT;
            GRANT: state_nxt = any_elig ? HOLD : IDLE;
            HOLD: begin
                if (bus.req_ready) begin
                    if (!bus.rty) begin
                        state_nxt = any_elig ? GRANT : IDLE;
                    end else if (rty_over) begin
                        drop_nxt  = 1'b1;
                        state_nxt = any_elig ? GRANT : IDLE;
                    end else begin
                        retry     = 1'b1;
                        state_nxt = (RTY_DLY == 0) ? HOLD : RWAIT;
                    end
                end
            end
            RWAIT: if (dly_cnt == 4'd0) state_nxt = HOLD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= CW'(NCH - 1);
            rty_cnt  <= '0;
            dly_cnt  <= '0;
            req_q    <= '0;
            req_ch_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            drop_q <= drop_nxt;
            if (state == GRANT && any_elig) begin
                req_q    <= bus.fifo_dout[pick];
                req_ch_q <= pick;
                rr_ptr   <= pick;
                rty_cnt  <= '0;
            end
            if (retry) begin
                rty_cnt <= (rty_cnt == 4'hF) ? rty_cnt : rty_cnt + 4'd1;
                dly_cnt <= 4'(RTY_DLY - 1);
            end else if (state == RWAIT) begin
                dly_cnt <= dly_cnt - 4'd1;
            end
        end
    end

    assign bus.fifo_rd   = rd_vec;
    assign bus.req       = req_q;
    assign bus.req_ch    = req_ch_q;
    assign bus.req_valid = (state == HOLD);
    assign bus.busy      = (state != IDLE);
    assign bus.drop      = drop_q;
endmodule

// File: tb/tb_mpmc11_req_sched.sv
// Directed bench for mpmc11_req_sched: FWFT FIFO model per channel, hand-computed grant
// order and handshake timing. Retry-drop expectations follow MPMC11_SCHED_RTYLIM_EN.
module tb_mpmc11_req_sched;
    localparam int NCH     = 8;
    localparam int EW      = 32;
    localparam int RTY_DLY = 3;
    localparam int RTY_MAX = 2;

    logic rd_clk;
    logic rst;
    logic model_init;

    mpmc11_req_sched_if #(.NCH(NCH), .EW(EW)) bus ();

    mpmc11_req_sched #(
        .NCH(NCH), .RTY_DLY(RTY_DLY), .RTY_MAX(RTY_MAX), .EW(EW)
    ) dut (
        .rd_clk(rd_clk),
        .rst   (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] mem [NCH][8];
    logic [2:0]    wp  [NCH];
    logic [2:0]    rp  [NCH];

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    always @(posedge rd_clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (model_init)
                rp[i] <= 3'd0;
            else if (bus.fifo_rd[i])
                rp[i] <= rp[i] + 3'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            bus.fifo_empty[i] = (wp[i] == rp[i]);
            bus.fifo_dout[i]  = mem[i][rp[i]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A pop must never hit an empty or reset-busy channel.
    always @(negedge rd_clk) begin
        if (!rst && bus.fifo_rd != '0)
            chk("rd_elig", 32'(bus.fifo_rd & (bus.fifo_empty | bus.fifo_rst_busy)), 32'h0);
    end

    task automatic load(input int ch, input logic [31:0] v);
        mem[ch][wp[ch]] = v;
        wp[ch] = wp[ch] + 3'd1;
    endtask

    task automatic step();
        @(negedge rd_clk);
    endtask

    // Called on the GRANT-cycle sample; returns on the sample after HOLD.
    task automatic grant(input int ch, input logic [31:0] v);
        chk("grant_rd", 32'(bus.fifo_rd), 32'(1 << ch));
        chk("grant_valid", 32'(bus.req_valid), 32'h0);
        step();
        chk("hold_valid", 32'(bus.req_valid), 32'h1);
        chk("hold_ch", 32'(bus.req_ch), 32'(ch));
        chk("hold_req", bus.req, v);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        model_init = 1'b1;
        bus.fifo_rst_busy = '0;
        bus.req_ready     = 1'b0;
        bus.rty           = 1'b0;
        for (int i = 0; i < NCH; i++) wp[i] = 3'd0;
        repeat (3) step();

        chk("rst_valid", 32'(bus.req_valid), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_rd", 32'(bus.fifo_rd), 32'h0);
        chk("rst_drop", 32'(bus.drop), 32'h0);
        chk("rst_req", bus.req, 32'h0);
        chk("rst_ch", 32'(bus.req_ch), 32'h0);
        rst        = 1'b0;
        model_init = 1'b0;

        // Two deep channels alternate; rr_ptr starts at 7 so ch2 leads.
        bus.req_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            load(2, 32'h200 + k);
            load(6, 32'h600 + k);
        end
        step();
        for (int i = 0; i < 8; i++)
            grant((i % 2 == 1) ? 6 : 2, ((i % 2 == 1) ? 32'h600 : 32'h200) + 32'(i / 2));
        chk("alt_idle", 32'(bus.busy), 32'h0);

        // rr_ptr=6: search wraps to 0, then 3, then 5.
        load(0, 32'h100);
        load(3, 32'h103);
        load(5, 32'h105);
        step();
        grant(0, 32'h100);
        grant(3, 32'h103);
        grant(5, 32'h105);
        chk("three_idle", 32'(bus.busy), 32'h0);

        // Core stalls for 10 cycles; rty toggling is ignored without ready.
        bus.req_ready = 1'b0;
        load(7, 32'h707);
        load(4, 32'h404);
        step();
        chk("stall_grant_rd", 32'(bus.fifo_rd), 32'h80);
        step();
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 32'(bus.req_valid), 32'h1);
            chk("stall_req", bus.req, 32'h707);
            chk("stall_ch", 32'(bus.req_ch), 32'h7);
            chk("stall_rd", 32'(bus.fifo_rd), 32'h0);
            bus.rty = (i % 2 == 0);
            step();
        end
        bus.rty       = 1'b0;
        bus.req_ready = 1'b1;
        step();
        grant(4, 32'h404);
        chk("stall_idle", 32'(bus.busy), 32'h0);

        // One retry: valid low for exactly RTY_DLY samples, then the same request.
        bus.req_ready = 1'b0;
        load(1, 32'h111);
        step();
        chk("rty_grant_rd", 32'(bus.fifo_rd), 32'h02);
        step();
        chk("rty_first_valid", 32'(bus.req_valid), 32'h1);
        bus.req_ready = 1'b1;
        bus.rty       = 1'b1;
        step();
        bus.req_ready = 1'b0;
        bus.rty       = 1'b0;
        repeat (3) begin
            chk("rty_gap_valid", 32'(bus.req_valid), 32'h0);
            chk("rty_gap_busy", 32'(bus.busy), 32'h1);
            step();
        end
        chk("rty_again_valid", 32'(bus.req_valid), 32'h1);
        chk("rty_again_req", bus.req, 32'h111);
        chk("rty_again_ch", 32'(bus.req_ch), 32'h1);
        bus.req_ready = 1'b1;
        step();
        chk("rty_done_valid", 32'(bus.req_valid), 32'h0);
        chk("rty_done_busy", 32'(bus.busy), 32'h0);
        chk("rty_done_drop", 32'(bus.drop), 32'h0);

        // Retry on every acceptance; with the limit at 2 the third retry drops.
        load(3, 32'h333);
        load(5, 32'h555);
        bus.rty = 1'b1;
        step();
        chk("lim_grant_rd", 32'(bus.fifo_rd), 32'h08);
        step();
        for (int p = 0; p < 3; p++) begin
            chk("lim_valid", 32'(bus.req_valid), 32'h1);
            chk("lim_req", bus.req, 32'h333);
            if (p < 2) begin
                step();
                repeat (3) begin
                    chk("lim_gap_valid", 32'(bus.req_valid), 32'h0);
                    step();
                end
            end
        end
`ifdef MPMC11_SCHED_RTYLIM_EN
        step();
        chk("lim_drop", 32'(bus.drop), 32'h1);
        chk("lim_drop_valid", 32'(bus.req_valid), 32'h0);
        chk("lim_next_rd", 32'(bus.fifo_rd), 32'h20);
        bus.rty = 1'b0;
        step();
        chk("lim_drop_end", 32'(bus.drop), 32'h0);
        chk("lim_next_valid", 32'(bus.req_valid), 32'h1);
        chk("lim_next_req", bus.req, 32'h555);
        chk("lim_next_ch", 32'(bus.req_ch), 32'h5);
        step();
`else
        step();
        repeat (3) begin
            chk("nolim_gap_valid", 32'(bus.req_valid), 32'h0);
            chk("nolim_drop", 32'(bus.drop), 32'h0);
            step();
        end
        chk("nolim_valid", 32'(bus.req_valid), 32'h1);
        chk("nolim_req", bus.req, 32'h333);
        bus.rty = 1'b0;
        step();
        chk("nolim_next_rd", 32'(bus.fifo_rd), 32'h20);
        chk("nolim_drop2", 32'(bus.drop), 32'h0);
        step();
        chk("nolim_next_valid", 32'(bus.req_valid), 32'h1);
        chk("nolim_next_req", bus.req, 32'h555);
        step();
`endif
        chk("lim_idle", 32'(bus.busy), 32'h0);

        // Reset while holding discards the request and restores ch0 priority.
        bus.req_ready = 1'b0;
        load(6, 32'h666);
        step();
        chk("rsthold_rd", 32'(bus.fifo_rd), 32'h40);
        step();
        chk("rsthold_valid", 32'(bus.req_valid), 32'h1);
        rst = 1'b1;
        step();
        chk("rsthold_valid0", 32'(bus.req_valid), 32'h0);
        chk("rsthold_busy0", 32'(bus.busy), 32'h0);
        chk("rsthold_req0", bus.req, 32'h0);
        chk("rsthold_rd0", 32'(bus.fifo_rd), 32'h0);
        rst = 1'b0;
        bus.req_ready = 1'b1;
        load(0, 32'hB0);
        load(1, 32'hB1);
        step();
        grant(0, 32'hB0);
        grant(1, 32'hB1);
        chk("rsthold_idle", 32'(bus.busy), 32'h0);

        // A channel in FIFO reset is ineligible even when non-empty.
        bus.fifo_rst_busy[2] = 1'b1;
        load(2, 32'hC2);
        repeat (3) begin
            step();
            chk("rstbusy_busy", 32'(bus.busy), 32'h0);
            chk("rstbusy_rd", 32'(bus.fifo_rd), 32'h0);
        end
        bus.fifo_rst_busy[2] = 1'b0;
        step();
        grant(2, 32'hC2);
        chk("rstbusy_idle", 32'(bus.busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mpmc11_req_sched.md
# mpmc11_req_sched

Read-side request scheduler for the mpmc11 memory controller. Drains up to NCH per-channel asynchronous request FIFOs (FWFT, distributed RAM) in round-robin order, registers one request at a time and presents it to the controller core with a valid/ready handshake. Re-presents any request the core rejects with `rty`. Lives entirely in the `rd_clk` (controller) domain, between the channel FIFOs and the command sequencer.

## Interface
- NCH, 8, number of requesting channels (2..16)
- RTY_DLY, 3, idle cycles inserted before a rejected request is re-presented (0..15)
- RTY_MAX, 15, consecutive retries before a request is dropped (used only with the retry-limit feature)

Ports:
- rd_clk  in  1  controller clock; all logic is on its rising edge
- rst  in  1  reset, synchronous, active-high
- fifo_empty  in  NCH  per-channel FIFO empty flags
- fifo_rst_busy  in  NCH  per-channel FIFO read-side reset busy; channel ineligible while high
- fifo_dout  in  NCH x mpmc11_fifoe_t  per-channel FWFT head entry; valid when corresponding empty=0
- fifo_rd  out  NCH  one-hot pop strobe, one cycle per grant
- req  out  mpmc11_fifoe_t  registered request to controller core
- req_ch  out  $clog2(NCH)  channel number of `req`
- req_valid  out  1  `req` is valid
- req_ready  in  1  core accepts `req` this cycle
- rty  in  1  qualifies `req_ready`: accepted-for-retry, not consumed
- drop  out  1  one-cycle pulse: request discarded after retry limit
- busy  out  1  state ≠ IDLE

## Operation
- Eligible[i] = ~fifo_empty[i] & ~fifo_rst_busy[i].
- FSM states: IDLE, GRANT, HOLD, RWAIT.
- IDLE: any eligible → GRANT; otherwise stay.
- GRANT: pick the first eligible channel searching upward from rr_ptr+1 (mod NCH). Pulse fifo_rd[ch], capture fifo_dout[ch] into `req`, set req_ch=ch and rr_ptr=ch, clear retry count. Go to HOLD. If nothing is eligible (flag changed), go to IDLE with no pop.
- HOLD: req_valid=1; `req`/`req_ch` stable.
  - req_ready & ~rty: consumed. Go to GRANT if any eligible, else IDLE.
  - req_ready & rty: increment retry count, load delay counter with RTY_DLY, go to RWAIT (or directly back to HOLD with req_valid kept high if RTY_DLY=0).
  - ~req_ready: stay; `rty` is ignored.
- RWAIT: req_valid=0; decrement delay counter. At 0 go to HOLD. No new grants while a request is held or waiting, so per-channel order is preserved.
- Retry count width is 4 bits and saturates at 15.
- Reset mid-operation: a held request (already popped) is discarded. FIFOs are not re-read.

## Timing
- Reset values: fifo_rd=0, req_valid=0, req=0, req_ch=0, drop=0, busy=0, state=IDLE, rr_ptr=NCH-1 (channel 0 has first priority), counters=0.
- Eligible in cycle N (from IDLE): GRANT in N+1 with fifo_rd high, req_valid high in N+2.
- Throughput: one request per 2 cycles (GRANT + HOLD), with immediate ready and continuous eligibility.
- Retry: rty seen in cycle N; req_valid low for N+1..N+RTY_DLY; high again in N+RTY_DLY+1.
- fifo_rd is never asserted for a channel whose empty or rst_busy flag is high in the same cycle.

## Configuration
- MPMC11_SCHED_RTYLIM_EN defined: when a retry would make the count exceed RTY_MAX, the request is dropped instead. drop pulses for one cycle, req_valid=0, and the FSM goes to GRANT or IDLE per eligibility.
- Not defined: the request is retried indefinitely; drop is tied to 0.

## Test plan
- Reset, then ch0, ch3 and ch5 nonempty with req_ready=1 → grants 0, 3, 5, each 2 cycles apart; fifo_rd one-hot each GRANT cycle.
- Ch2 holds 4 entries and ch6 holds 4 entries, continuous ready → order 2, 6, 2, 6, 2, 6, 2, 6. Each req equals its FIFO head at pop.
- req_ready held low for 10 cycles → req, req_ch and req_valid stable; no fifo_rd pulses.
- RTY_DLY=3, one rty on a ch1 request → req_valid low exactly 3 cycles, then the same req is re-presented. A second acceptance with rty=0 consumes it.
- With MPMC11_SCHED_RTYLIM_EN and RTY_MAX=2, rty on every acceptance → third rty yields a drop pulse and the next channel is granted. Without the macro, the request is re-presented indefinitely.
- rst asserted in HOLD → the next cycle has req_valid=0, busy=0, rr_ptr=NCH-1; after release, channel 0 wins a 0/1 tie.
